// File: rtl/edram_pkg.sv
// Shared definitions for the tile eDRAM port and the arbiter that owns it.
//   EDRAM_NUM_IMA    default number of IMA requesters
//   EDRAM_ADDR_WIDTH default eDRAM word address width
//   EDRAM_DATA_WIDTH default eDRAM word width (opaque payload)
//   EDRAM_MEM_LAT    default fixed access latency in cycles (>= 1)
//   state_t          arbiter sequencer state {FREE, BUSY}
package edram_pkg;

    localparam int EDRAM_NUM_IMA    = 4;
    localparam int EDRAM_ADDR_WIDTH = 20;
    localparam int EDRAM_DATA_WIDTH = 12;
    localparam int EDRAM_MEM_LAT    = 4;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-priority encoder.
// The search starts at rr_ptr and walks upward with wrap-around; the first
// asserted request wins.
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  ID_W     index with the highest priority this cycle
//   gnt_valid out 1        at least one request is set
//   gnt_id    out ID_W     index of the winning request (0 when none)
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NUM_REQ;
    endfunction

    // Walk from the farthest offset back to rr_ptr so the candidate closest
    // to the pointer is the last one written and therefore wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(int'(rr_ptr), k)]) begin
                gnt_valid = 1'b1;
                gnt_id    = ID_W'(wrap_idx(int'(rr_ptr), k));
            end
        end
    end

endmodule

// File: rtl/edram_rr_arbiter.sv
// Round-robin arbiter and sequencer for the single tile eDRAM port.
// One read or write is granted at a time; the eDRAM command is held stable
// for MEM_LAT cycles and completion is returned through ima_wait.
//   clk, rst       clock, synchronous active-high reset
//   ima_ren/wen    per-IMA read / write request (both set = write)
//   ima_addr       per-IMA address, flattened NUM_IMA x ADDR_WIDTH
//   ima_wdata      per-IMA write data, flattened NUM_IMA x DATA_WIDTH
//   ima_wait       per-IMA: 1 = request pending, keep holding it
//   ima_rvalid     one-hot read-data strobe
//   ima_rdata      shared read-data bus, qualified by ima_rvalid
//   ram_ren/wen    eDRAM read / write enable
//   ram_addr       eDRAM address
//   ram_wdata      eDRAM write data
//   ram_rdata      eDRAM read data, valid in the last access cycle
//
// Handshake: an IMA raises ren and/or wen with addr/wdata and holds all of
// them while its ima_wait bit reads 1. The cycle its ima_wait bit drops to 0
// with the request still high is the completion cycle; the IMA may drop or
// change its request on the following edge. Read data arrives one cycle after
// completion on ima_rdata with the IMA's ima_rvalid bit set.
module edram_rr_arbiter
    import edram_pkg::*;
#(
    parameter int NUM_IMA    = EDRAM_NUM_IMA,
    parameter int ADDR_WIDTH = EDRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = EDRAM_DATA_WIDTH,
    parameter int MEM_LAT    = EDRAM_MEM_LAT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IMA-1:0]               ima_ren,
    input  logic [NUM_IMA-1:0]               ima_wen,
    input  logic [NUM_IMA*ADDR_WIDTH-1:0]    ima_addr,
    input  logic [NUM_IMA*DATA_WIDTH-1:0]    ima_wdata,
    output logic [NUM_IMA-1:0]               ima_wait,
    output logic [NUM_IMA-1:0]               ima_rvalid,
    output logic [DATA_WIDTH-1:0]            ima_rdata,
    output logic                             ram_ren,
    output logic                             ram_wen,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_wdata,
    input  logic [DATA_WIDTH-1:0]            ram_rdata
);

    localparam int ID_W  = (NUM_IMA > 1) ? $clog2(NUM_IMA) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_IMA - 1);

    state_t                 state;
    state_t                 state_next;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        id;
    logic [ID_W-1:0]        gnt_id;
    logic                   gnt_valid;
    logic [CNT_W-1:0]       cnt;
    logic                   op_wr;
    logic                   done;
    logic [NUM_IMA-1:0]     req;
    logic [NUM_IMA-1:0]     done_hit;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [NUM_IMA-1:0]     rvalid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    assign req  = ima_ren | ima_wen;
    assign done = (state == BUSY) && (cnt == '0);

    // One-hot of the owner, only in the completion cycle.
    always_comb begin
        done_hit = '0;
        for (int i = 0; i < NUM_IMA; i++) begin
            done_hit[i] = done && (id == ID_W'(i));
        end
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_IMA),
        .ID_W    (ID_W)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_next = state;
        case (state)
            FREE:    if (gnt_valid) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = FREE;
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            rr_ptr   <= '0;
            cnt      <= '0;
            id       <= '0;
            op_wr    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_next;
            rvalid_q <= '0;
            if (state == FREE) begin
                if (gnt_valid) begin
                    id      <= gnt_id;
                    // wen wins when an IMA raises both enables.
                    op_wr   <= ima_wen[gnt_id];
                    addr_q  <= ima_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_q <= ima_wdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
                    cnt     <= CNT_LOAD;
                    rr_ptr  <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
                end
            end else begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end
                // The strobe fires even if the owner already dropped its request.
                if (done && !op_wr) begin
                    rvalid_q <= done_hit;
                    rdata_q  <= ram_rdata;
                end
            end
        end
    end

    assign ima_wait   = req & ~done_hit;
    assign ima_rvalid = rvalid_q;
    assign ima_rdata  = rdata_q;
    assign ram_ren    = (state == BUSY) && !op_wr;
    assign ram_wen    = (state == BUSY) &&  op_wr;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;

endmodule
